// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM states,
// trap cause codes and the EXEC-stage dispatch helper.
package core_sequencer_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        StRst   = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StMemRd = 3'd3,
        StMemWr = 3'd4,
        StCommit = 3'd5,
        StTrap  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_MISALIGN = 2'd2,
        TRAP_TIMEOUT  = 2'd3
    } trap_cause_e;

    // FENCE and SYSTEM are deliberately unsupported and land in TRAP.
    function automatic state_e exec_next(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD:  return StMemRd;
            OPC_STORE: return StMemWr;
            OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC: return StCommit;
            default:   return StTrap;
        endcase
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles a bus request waits for ack; flags expiry on the cycle the
// wait would reach ACK_TIMEOUT. ACK_TIMEOUT=0 disables it.
module bus_watchdog #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            cnt_q <= '0;
        end else if (busy && !ack && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Ack in the expiry cycle suppresses the trap.
    generate
        if (ACK_TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = busy && !ack && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer around the combinational RV32I control unit: shares one
// req/ack memory port for fetch and data, and commits each instruction once.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ack_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    input  logic [31:0] pc_next_in,
    input  logic [31:0] dmem_rd_addr_in,
    input  logic [31:0] dmem_wr_addr_in,
    input  logic [31:0] dmem_wr_data_in,
    output logic [31:0] dmem_rd_data_out,
    input  logic        reg_wr_en_in,
    output logic        reg_wr_en_out,
    output logic        trap_out,
    output logic [1:0]  trap_cause_out,
    output logic [31:0] instret_out
);

    state_e      state_q;
    trap_cause_e cause_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] ld_data_q;
    logic [31:0] instret_q;
    logic        expired;
    state_e      exec_target;

    assign exec_target = exec_next(instr_q[6:0]);

    bus_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_bus_watchdog (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (~mem_req_out),
        .busy   (mem_req_out),
        .ack    (mem_ack_in),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= StRst;
            cause_q   <= TRAP_NONE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ld_data_q <= '0;
            instret_q <= '0;
        end else begin
            unique case (state_q)
                StRst: state_q <= StFetch;
                StFetch: begin
                    if (pc_q[1:0] != 2'b00) begin
                        state_q <= StTrap;
                        cause_q <= TRAP_MISALIGN;
                    end else if (mem_ack_in) begin
                        instr_q <= mem_rdata_in;
                        state_q <= StExec;
                    end else if (expired) begin
                        state_q <= StTrap;
                        cause_q <= TRAP_TIMEOUT;
                    end
                end
                StExec: begin
                    state_q <= exec_target;
                    if (exec_target == StTrap) begin
                        cause_q <= TRAP_ILLEGAL;
                    end
                end
                StMemRd: begin
                    if (mem_ack_in) begin
                        ld_data_q <= mem_rdata_in;
                        state_q   <= StCommit;
                    end else if (expired) begin
                        state_q <= StTrap;
                        cause_q <= TRAP_TIMEOUT;
                    end
                end
                StMemWr: begin
                    if (mem_ack_in) begin
                        state_q <= StCommit;
                    end else if (expired) begin
                        state_q <= StTrap;
                        cause_q <= TRAP_TIMEOUT;
                    end
                end
                StCommit: begin
                    pc_q      <= pc_next_in;
                    instret_q <= instret_q + 32'd1;
                    state_q   <= StFetch;
                end
                StTrap: state_q <= StTrap;
                default: begin
                    state_q <= StTrap;
                    cause_q <= TRAP_ILLEGAL;
                end
            endcase
        end
    end

    // Bus outputs decode the current state; a misaligned fetch never requests.
    always_comb begin
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        case (state_q)
            StFetch: begin
                if (pc_q[1:0] == 2'b00) begin
                    mem_req_out  = 1'b1;
                    mem_addr_out = pc_q;
                end
            end
            StMemRd: begin
                mem_req_out  = 1'b1;
                mem_addr_out = dmem_rd_addr_in;
            end
            StMemWr: begin
                mem_req_out   = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = dmem_wr_addr_in;
                mem_wdata_out = dmem_wr_data_in;
            end
            default: ;
        endcase
    end

    assign reg_wr_en_out    = (state_q == StCommit) && reg_wr_en_in;
    assign trap_out         = (state_q == StTrap);
    assign trap_cause_out   = cause_q;
    assign pc_out           = pc_q;
    assign instr_out        = instr_q;
    assign dmem_rd_data_out = ld_data_q;
    assign instret_out      = instret_q;

endmodule
